// File: rtl/hfswr_clk_pkg.sv
// Shared definitions for the divided-clock timing chain.
//   mon_state_t : state encoding of the clk_div_monitor FSM
//   DIV_HALF    : divider half-period in system clocks (toggle interval)
//   DIV_PERIOD  : full divided-clock period in system clocks
package hfswr_clk_pkg;

   typedef enum logic {
      ACQUIRE = 1'b0,   // waiting for an edge to re-arm the period counter
      TRACK   = 1'b1    // counting cycles between edges
   } mon_state_t;

   localparam int DIV_HALF   = 18433;
   localparam int DIV_PERIOD = 2 * DIV_HALF;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Status bundle of the divided-clock monitor.
//   clk_in       : divided clock under test (asynchronous to the system clock)
//   edge_pulse   : one-cycle pulse per detected rising edge of clk_in
//   period       : last measured period, held
//   period_valid : one-cycle strobe when period updates
//   in_range     : last period within tolerance, held
//   lock         : run of consecutive in-range periods seen
//   lost         : no edge for the timeout interval
// master : the monitor (consumes clk_in, drives status)
// slave  : the surrounding system (drives clk_in, consumes status)
//
// Handshake: there is no back-pressure. period_valid is a one-cycle strobe,
// coincident with edge_pulse; period and in_range are valid from that cycle
// and held until the next strobe. lock and lost are level flags.
interface clk_div_monitor_if #(
   parameter int CNT_W = 17
);
   logic             clk_in;
   logic             edge_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             in_range;
   logic             lock;
   logic             lost;

   modport master (
      input  clk_in,
      output edge_pulse, period, period_valid, in_range, lock, lost
   );

   modport slave (
      output clk_in,
      input  edge_pulse, period, period_valid, in_range, lock, lost
   );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous input.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   async_i : asynchronous input level
//   rise_o  : combinational rise indication (s2 & ~s3), for logic that must
//             act in the same cycle the registered pulse appears
//   pulse_o : registered one-cycle pulse per rising edge of async_i
// Latency: async_i first sampled high at edge N -> pulse_o high after edge N+2.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o,
   output logic pulse_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;
   logic pulse_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= async_i;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pulse_q <= rise_o;
      end
   end

   assign rise_o  = s2_q & ~s3_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: resynchronises clk_in, measures the period between
// rising edges in system clocks, range-checks it, tracks lock and flags loss.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   mon     : status bundle (clk_in in, measurement/health flags out)
//   state_o : current FSM state, for observation
// All status outputs are registered and update in the cycle edge_pulse is high.
module clk_div_monitor
   import hfswr_clk_pkg::*;
#(
   parameter int EXP_PERIOD = DIV_PERIOD,
   parameter int TOL        = 64,
   parameter int LOCK_N     = 4,
   parameter int TIMEOUT    = 2 * DIV_PERIOD,
   parameter int CNT_W      = 17
) (
   input  logic                clk,
   input  logic                rst,
   clk_div_monitor_if.master   mon,
   output mon_state_t          state_o
);

   localparam int LCW = $clog2(LOCK_N + 1);

   localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [LCW-1:0]   LOCK_C    = LCW'(LOCK_N);

   logic rise;
   logic pulse;

   sync_edge_det u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (mon.clk_in),
      .rise_o  (rise),
      .pulse_o (pulse)
   );

   mon_state_t       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] period_q,   period_d;
   logic             valid_q,    valid_d;
   logic             in_range_q, in_range_d;
   logic             lock_q,     lock_d;
   logic             lost_q,     lost_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

   // cnt_q counts cycles since the last edge minus one, so cnt+1 is the
   // period if an edge is seen now.
   logic [CNT_W-1:0] cnt_inc;
   logic             meas_ok;

   assign cnt_inc = cnt_q + 1'b1;
   assign meas_ok = (cnt_inc >= LO_LIM) && (cnt_inc <= HI_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ACQUIRE;
         cnt_q      <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         in_range_q <= 1'b0;
         lock_q     <= 1'b0;
         lost_q     <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         in_range_q <= in_range_d;
         lock_q     <= lock_d;
         lost_q     <= lost_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_d   = period_q;
      valid_d    = 1'b0;
      in_range_d = in_range_q;
      lock_d     = lock_q;
      lost_d     = lost_q;
      lock_cnt_d = lock_cnt_q;

      case (state_q)
         ACQUIRE: begin
            cnt_d = '0;
            // First edge only re-arms the counter; nothing to measure yet.
            if (rise) begin
               state_d = TRACK;
               lost_d  = 1'b0;
            end
         end

         TRACK: begin
            cnt_d = cnt_inc;
            // An edge coincident with the timeout is a real (long) period.
            if (rise) begin
               cnt_d      = '0;
               period_d   = cnt_inc;
               valid_d    = 1'b1;
               in_range_d = meas_ok;
               if (meas_ok) begin
                  if (lock_cnt_q != LOCK_C) begin
                     lock_cnt_d = lock_cnt_q + 1'b1;
                  end
                  lock_d = (lock_cnt_d == LOCK_C);
               end else begin
                  lock_cnt_d = '0;
                  lock_d     = 1'b0;
               end
            end else if (cnt_inc == TIMEOUT_C) begin
               state_d    = ACQUIRE;
               cnt_d      = '0;
               lost_d     = 1'b1;
               lock_d     = 1'b0;
               lock_cnt_d = '0;
            end
         end

         default: state_d = ACQUIRE;
      endcase
   end

   assign mon.edge_pulse   = pulse;
   assign mon.period       = period_q;
   assign mon.period_valid = valid_q;
   assign mon.in_range     = in_range_q;
   assign mon.lock         = lock_q;
   assign mon.lost         = lost_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;
   import hfswr_clk_pkg::*;

   localparam int CNT_W = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   mon_state_t dut_state;

   always #5 clk = ~clk;

   clk_div_monitor_if #(.CNT_W(CNT_W)) mon_if ();

   clk_div_monitor #(
      .EXP_PERIOD (20),
      .TOL        (2),
      .LOCK_N     (3),
      .TIMEOUT    (40),
      .CNT_W      (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mon     (mon_if),
      .state_o (dut_state)
   );

   int total = 0;
   int bad   = 0;

   // snapshot taken in the cycle where the edge_pulse of a driven rise is due
   logic             s_pulse, s_valid, s_in_range, s_lock, s_lost;
   logic [CNT_W-1:0] s_period;
   int               n_pulse, n_valid, n_lost;

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One period of clk_in: rise now, fall at p/2, p cycles total. The pulse
   // for this rise is due 3 cycles after the rise; it reports the previous
   // period's length.
   task automatic run_period(input int p);
      n_pulse = 0;
      n_valid = 0;
      n_lost  = 0;
      mon_if.clk_in = 1'b1;
      for (int i = 0; i < p; i++) begin
         if (i == p / 2) mon_if.clk_in = 1'b0;
         cyc();
         if (i == 2) begin
            s_pulse    = mon_if.edge_pulse;
            s_valid    = mon_if.period_valid;
            s_period   = mon_if.period;
            s_in_range = mon_if.in_range;
            s_lock     = mon_if.lock;
            s_lost     = mon_if.lost;
         end
         n_pulse += int'(mon_if.edge_pulse);
         n_valid += int'(mon_if.period_valid);
         n_lost  += int'(mon_if.lost);
      end
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if (mon_if.edge_pulse !== 1'b0 || mon_if.period !== '0 || mon_if.period_valid !== 1'b0 ||
          mon_if.in_range !== 1'b0 || mon_if.lock !== 1'b0 || mon_if.lost !== 1'b0) begin
         bad++;
         $display("FAIL %s: outputs pulse=%b period=%0d valid=%b in_range=%b lock=%b lost=%b, want all 0",
                  tag, mon_if.edge_pulse, mon_if.period, mon_if.period_valid, mon_if.in_range,
                  mon_if.lock, mon_if.lost);
      end
      total++;
      if (dut_state !== ACQUIRE) begin
         bad++;
         $display("FAIL %s_state: got %0d want ACQUIRE", tag, dut_state);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      mon_if.clk_in = 1'b0;
      cyc();
      cyc();
      check_all_zero("reset");
      rst = 1'b0;
      cyc();
      cyc();
   endtask

   // Five periods of 20: re-arm, then 20/in-range each time, lock on the 3rd.
   task automatic test_square(input string tag);
      run_period(20);
      total++;
      if (s_pulse !== 1'b1 || n_pulse != 1) begin
         bad++;
         $display("FAIL %s_arm_pulse: pulse=%b count=%0d want 1/1", tag, s_pulse, n_pulse);
      end
      total++;
      if (n_valid != 0) begin
         bad++;
         $display("FAIL %s_arm_novalid: valid count=%0d want 0", tag, n_valid);
      end
      for (int k = 1; k <= 4; k++) begin
         run_period(20);
         total++;
         if (s_valid !== 1'b1 || n_valid != 1 || s_period !== 8'd20 || s_in_range !== 1'b1) begin
            bad++;
            $display("FAIL %s_meas%0d: valid=%b cnt=%0d period=%0d in_range=%b want 1/1/20/1",
                     tag, k, s_valid, n_valid, s_period, s_in_range);
         end
         total++;
         if (s_lock !== (k >= 3)) begin
            bad++;
            $display("FAIL %s_lock%0d: got %b want %b", tag, k, s_lock, (k >= 3));
         end
      end
   endtask

   // Locked, one 25, then 19, 21, 20: lock returns on the 20 measurement.
   task automatic test_out_of_range();
      int             per   [5] = '{25, 19, 21, 20, 20};
      logic [CNT_W-1:0] exp_p [5] = '{8'd20, 8'd25, 8'd19, 8'd21, 8'd20};
      logic           exp_r [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic           exp_l [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         run_period(per[k]);
         total++;
         if (s_valid !== 1'b1 || s_period !== exp_p[k] || s_in_range !== exp_r[k] || s_lock !== exp_l[k]) begin
            bad++;
            $display("FAIL oor_step%0d: valid=%b period=%0d in_range=%b lock=%b want 1/%0d/%b/%b",
                     k, s_valid, s_period, s_in_range, s_lock, exp_p[k], exp_r[k], exp_l[k]);
         end
      end
   endtask

   // Stop toggling while locked: lost exactly 40 cycles after the last pulse.
   task automatic test_loss();
      int   first_lost = -1;
      logic lock_before = 1'b0;
      logic lock_at_lost = 1'b1;
      // 17 cycles have already elapsed since the last pulse.
      for (int j = 1; j <= 30; j++) begin
         cyc();
         if (j == 22) lock_before = mon_if.lock;
         if (mon_if.lost === 1'b1 && first_lost < 0) begin
            first_lost   = j;
            lock_at_lost = mon_if.lock;
         end
      end
      total++;
      if (first_lost != 23) begin
         bad++;
         $display("FAIL loss_time: lost after %0d cycles want %0d", first_lost + 17, 40);
      end
      total++;
      if (lock_before !== 1'b1 || lock_at_lost !== 1'b0) begin
         bad++;
         $display("FAIL loss_lock: before=%b at_lost=%b want 1/0", lock_before, lock_at_lost);
      end
      total++;
      if (dut_state !== ACQUIRE) begin
         bad++;
         $display("FAIL loss_state: got %0d want ACQUIRE", dut_state);
      end
      run_period(20);
      total++;
      if (s_pulse !== 1'b1 || s_lost !== 1'b0 || n_valid != 0) begin
         bad++;
         $display("FAIL loss_rearm: pulse=%b lost=%b valid count=%0d want 1/0/0", s_pulse, s_lost, n_valid);
      end
      run_period(20);
      total++;
      if (s_valid !== 1'b1 || s_period !== 8'd20 || s_in_range !== 1'b1 || s_lock !== 1'b0) begin
         bad++;
         $display("FAIL loss_first_period: valid=%b period=%0d in_range=%b lock=%b want 1/20/1/0",
                  s_valid, s_period, s_in_range, s_lock);
      end
   endtask

   // Edge lands exactly when the count reaches the timeout: edge wins.
   task automatic test_edge_at_timeout();
      run_period(40);
      total++;
      if (n_lost != 0) begin
         bad++;
         $display("FAIL tmo_nolost_during: lost cycles=%0d want 0", n_lost);
      end
      run_period(20);
      total++;
      if (s_valid !== 1'b1 || s_period !== 8'd40 || s_in_range !== 1'b0) begin
         bad++;
         $display("FAIL tmo_period: valid=%b period=%0d in_range=%b want 1/40/0", s_valid, s_period, s_in_range);
      end
      total++;
      if (s_lost !== 1'b0 || n_lost != 0 || dut_state !== TRACK) begin
         bad++;
         $display("FAIL tmo_nolost: lost=%b cycles=%0d state=%0d want 0/0/TRACK", s_lost, n_lost, dut_state);
      end
   endtask

   // Reset mid-period while locked, then the square-wave scenario again.
   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) run_period(20);
      total++;
      if (s_lock !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_locked: lock=%b want 1", s_lock);
      end
      mon_if.clk_in = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      rst = 1'b1;
      #1;
      check_all_zero("rstmid");
      mon_if.clk_in = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      cyc();
      test_square("after_rst");
   endtask

   // clk_in rises one cycle after reset release: pulse 3 cycles later, once.
   task automatic test_first_edge_latency();
      logic exp_pulse;
      rst = 1'b1;
      mon_if.clk_in = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      mon_if.clk_in = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         exp_pulse = (i == 3);
         total++;
         if (mon_if.edge_pulse !== exp_pulse) begin
            bad++;
            $display("FAIL lat_cycle%0d: pulse=%b want %b", i, mon_if.edge_pulse, exp_pulse);
         end
      end
      n_pulse = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_pulse += int'(mon_if.edge_pulse);
      end
      total++;
      if (n_pulse != 0 || dut_state !== TRACK) begin
         bad++;
         $display("FAIL lat_held_high: extra pulses=%0d state=%0d want 0/TRACK", n_pulse, dut_state);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      mon_if.clk_in = 1'b0;
      test_reset();
      test_square("square");
      test_out_of_range();
      test_loss();
      test_edge_at_timeout();
      test_reset_mid();
      test_first_edge_latency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
